// File: rtl/i2s_clk_pkg.sv
// ---------------------------------------------------------------------------
// i2s_clk_pkg
// Shared definitions for the audio clock generator:
//   - mode_e  : framing mode (I2S 50 % LRCLK or DSP one-BCLK frame sync)
//   - state_e : run-control states of the BCLK/LRCLK engine
//   - idx_width() and default-width localparams used to size index ports
// ---------------------------------------------------------------------------
package i2s_clk_pkg;

    typedef enum logic {
        MODE_I2S = 1'b0,
        MODE_DSP = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_DRAINING = 2'd2
    } state_e;

    // Index widths never collapse to zero bits, even for a count of one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_MCLK_HALF_DIV = 5;
    localparam int DEF_BCLK_HALF_DIV = 2;
    localparam int DEF_SLOT_WIDTH    = 32;
    localparam int DEF_N_SLOTS       = 2;
    localparam int DEF_SLOT_IDX_W    = idx_width(DEF_N_SLOTS);
    localparam int DEF_BIT_IDX_W     = idx_width(DEF_SLOT_WIDTH);

endpackage

// File: rtl/clk_div_ce.sv
// ---------------------------------------------------------------------------
// clk_div_ce
// Generic terminal-count divider. Counts 0..DIV-1 on every cycle where 'ce'
// is high and raises 'tick' combinationally in the cycle the count sits at
// its terminal value, so the parent can toggle a clock in that same cycle.
// Ports:
//   sys_clk, reset : clock and asynchronous active-high reset
//   clear          : synchronous clear, overrides ce and suppresses tick
//   ce             : count enable
//   tick           : terminal-count strobe (ce && count == DIV-1)
// ---------------------------------------------------------------------------
module clk_div_ce
    import i2s_clk_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic clear,
    input  logic ce,
    output logic tick
);

    localparam int            CW   = idx_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // The strobe is gated by clear so a held-off divider never reports an
    // edge, even if a stale terminal count were still present.
    assign tick = ce && !clear && (count == LAST);

    // Count register: clears synchronously on 'clear', wraps at DIV-1 when
    // enabled, and otherwise holds so the phase survives disabled cycles.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (ce) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_clock_gen.sv
// ---------------------------------------------------------------------------
// i2s_clock_gen
// Audio clock generator producing MCLK, BCLK and LRCLK/FS from sys_clk with
// frame-aligned start and graceful stop.
// Parameters:
//   mclk_half_div : sys_clk cycles per MCLK half-period (>=1)
//   bclk_half_div : MCLK periods per BCLK half-period (>=1)
//   slot_width    : BCLK periods per slot (>=8)
//   n_slots       : slots per frame (even, 2..16)
// Ports:
//   sys_clk, reset : clock and asynchronous active-high reset
//   clk_lock       : PLL lock; low holds everything stopped and cleared
//   enable         : request BCLK/LRCLK run
//   mode           : 0 = I2S, 1 = DSP/TDM (sampled at frame boundaries)
//   mclk, bclk     : generated clocks (registered)
//   lrclk          : LRCLK in I2S mode, frame-sync pulse in DSP mode
//   bclk_rise/fall : one-cycle strobes in the cycle bclk changes
//   frame_start    : strobe on the fall that begins slot 0, bit 0
//   slot, bit_idx  : current slot and bit (bit 0 is the MSB)
//   running        : BCLK engine active (RUNNING or DRAINING)
// ---------------------------------------------------------------------------
module i2s_clock_gen
    import i2s_clk_pkg::*;
#(
    parameter int mclk_half_div = DEF_MCLK_HALF_DIV,
    parameter int bclk_half_div = DEF_BCLK_HALF_DIV,
    parameter int slot_width    = DEF_SLOT_WIDTH,
    parameter int n_slots       = DEF_N_SLOTS
) (
    input  logic                             sys_clk,
    input  logic                             reset,
    input  logic                             clk_lock,
    input  logic                             enable,
    input  logic                             mode,
    output logic                             mclk,
    output logic                             bclk,
    output logic                             lrclk,
    output logic                             bclk_rise,
    output logic                             bclk_fall,
    output logic                             frame_start,
    output logic [idx_width(n_slots)-1:0]    slot,
    output logic [idx_width(slot_width)-1:0] bit_idx,
    output logic                             running
);

    localparam int                SLOT_W     = idx_width(n_slots);
    localparam int                BIT_W      = idx_width(slot_width);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(n_slots - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF  = SLOT_W'(n_slots / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(slot_width - 1);

    state_e            state_q;
    state_e            state_d;
    mode_e             mode_lat;
    mode_e             mode_lat_d;

    logic              mclk_d;
    logic              bclk_d;
    logic              lrclk_d;
    logic              rise_d;
    logic              fall_d;
    logic              fs_d;
    logic              running_d;
    logic [SLOT_W-1:0] slot_d;
    logic [BIT_W-1:0]  bit_d;

    logic              mclk_tick;
    logic              mclk_rise_ev;
    logic              bclk_tick;
    logic              bclk_clear;
    logic              is_rise;
    logic              is_fall;

    logic              bit_wrap;
    logic              wrap_frame;
    logic [BIT_W-1:0]  bit_nx;
    logic [SLOT_W-1:0] slot_nx;
    logic [SLOT_W-1:0] slot_after;

    // MCLK half-period divider: free-runs whenever the PLL is locked.
    clk_div_ce #(
        .DIV (mclk_half_div)
    ) u_mclk_div (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (!clk_lock),
        .ce      (clk_lock),
        .tick    (mclk_tick)
    );

    // A BCLK edge may only happen on an MCLK rising event, which keeps
    // BCLK phase-locked to MCLK.
    assign mclk_rise_ev = mclk_tick && !mclk;
    assign bclk_clear   = !clk_lock || (state_q == ST_STOPPED);

    // BCLK half-period divider, stepped by MCLK rising events while the
    // engine is active; held cleared while stopped so every start begins
    // with a full low half-period.
    clk_div_ce #(
        .DIV (bclk_half_div)
    ) u_bclk_div (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (bclk_clear),
        .ce      (mclk_rise_ev),
        .tick    (bclk_tick)
    );

    assign is_rise = bclk_tick && !bclk;
    assign is_fall = bclk_tick && bclk;

    // Position arithmetic for the next falling edge: bit index wraps at the
    // slot width, the slot steps on each bit wrap, and a combined wrap marks
    // the start of a new frame. slot_after is the slot following the new one
    // and decides the LRCLK half one BCLK ahead of its MSB.
    always_comb begin
        bit_wrap   = (bit_idx == BIT_LAST);
        wrap_frame = bit_wrap && (slot == SLOT_LAST);
        bit_nx     = bit_wrap ? '0 : bit_idx + BIT_W'(1);
        slot_nx    = slot;
        if (bit_wrap) begin
            slot_nx = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        end
        slot_after = (slot_nx == SLOT_LAST) ? '0 : slot_nx + SLOT_W'(1);
    end

    // State register for the run-control FSM.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Lock loss beats everything. Starting waits for an
    // MCLK rising event so BCLK begins aligned. Dropping enable drains to
    // the end of the frame; the drain ends on the fall that would otherwise
    // begin the next frame, unless enable has come back first.
    always_comb begin
        state_d = state_q;
        if (!clk_lock) begin
            state_d = ST_STOPPED;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (enable && mclk_rise_ev) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (!enable) begin
                        state_d = ST_DRAINING;
                    end
                end
                ST_DRAINING: begin
                    if (enable) begin
                        state_d = ST_RUNNING;
                    end else if (is_fall && wrap_frame) begin
                        state_d = ST_STOPPED;
                    end
                end
                default: begin
                    state_d = ST_STOPPED;
                end
            endcase
        end
    end

    // Output/datapath next values. On start the indices are parked on the
    // last bit of the last slot so the very first fall produces frame_start
    // after exactly one BCLK period of lead (FS high in DSP, LRCLK low in
    // I2S). Within a frame every decision uses the latched mode; the new
    // mode is taken only on the frame_start fall, so a mid-frame change
    // never reshapes the frame in progress.
    always_comb begin
        mclk_d     = mclk;
        bclk_d     = bclk;
        lrclk_d    = lrclk;
        slot_d     = slot;
        bit_d      = bit_idx;
        running_d  = running;
        mode_lat_d = mode_lat;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        fs_d       = 1'b0;

        if (mclk_tick) begin
            mclk_d = ~mclk;
        end

        if (!clk_lock) begin
            mclk_d     = 1'b0;
            bclk_d     = 1'b0;
            lrclk_d    = 1'b0;
            slot_d     = '0;
            bit_d      = '0;
            running_d  = 1'b0;
            mode_lat_d = MODE_I2S;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (state_d == ST_RUNNING) begin
                        bclk_d     = 1'b0;
                        slot_d     = SLOT_LAST;
                        bit_d      = BIT_LAST;
                        running_d  = 1'b1;
                        mode_lat_d = mode_e'(mode);
                        lrclk_d    = (mode_e'(mode) == MODE_DSP);
                    end
                end
                default: begin
                    running_d = 1'b1;
                    if (is_rise) begin
                        bclk_d = 1'b1;
                        rise_d = 1'b1;
                    end
                    if (is_fall) begin
                        bclk_d = 1'b0;
                        fall_d = 1'b1;
                        if (state_d == ST_STOPPED) begin
                            lrclk_d   = 1'b0;
                            slot_d    = '0;
                            bit_d     = '0;
                            running_d = 1'b0;
                        end else begin
                            bit_d  = bit_nx;
                            slot_d = slot_nx;
                            fs_d   = wrap_frame;
                            if (wrap_frame) begin
                                mode_lat_d = mode_e'(mode);
                            end
                            if (mode_lat == MODE_DSP) begin
                                lrclk_d = (bit_nx == BIT_LAST) && (slot_nx == SLOT_LAST);
                            end else if (bit_nx == BIT_LAST) begin
                                lrclk_d = (slot_after >= SLOT_HALF);
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Output registers: every port is driven from a flop on sys_clk.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            mclk        <= 1'b0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            slot        <= '0;
            bit_idx     <= '0;
            running     <= 1'b0;
            mode_lat    <= MODE_I2S;
        end else begin
            mclk        <= mclk_d;
            bclk        <= bclk_d;
            lrclk       <= lrclk_d;
            bclk_rise   <= rise_d;
            bclk_fall   <= fall_d;
            frame_start <= fs_d;
            slot        <= slot_d;
            bit_idx     <= bit_d;
            running     <= running_d;
            mode_lat    <= mode_lat_d;
        end
    end

endmodule

// File: tb/tb_i2s_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_i2s_clock_gen
// Bench for i2s_clock_gen with non-power-of-two slot width and slot count so
// every wrap point is exercised. A reference model derives the expected
// clocks and indices from elapsed time since start (BCLK period arithmetic
// and frame position), pushes expected strobe events into a queue, and a
// monitor pops and compares whenever the DUT emits a strobe.
// ---------------------------------------------------------------------------
module tb_i2s_clock_gen;

    localparam int MHD   = 3;
    localparam int BHD   = 2;
    localparam int SW    = 10;
    localparam int NS    = 6;
    localparam int BP    = 4 * MHD * BHD;
    localparam int FRAME = SW * NS;
    localparam int SLW   = $clog2(NS);
    localparam int BW    = $clog2(SW);

    logic           sys_clk = 1'b0;
    logic           reset   = 1'b1;
    logic           clk_lock = 1'b0;
    logic           enable   = 1'b0;
    logic           mode     = 1'b0;
    logic           mclk;
    logic           bclk;
    logic           lrclk;
    logic           bclk_rise;
    logic           bclk_fall;
    logic           frame_start;
    logic [SLW-1:0] slot;
    logic [BW-1:0]  bit_idx;
    logic           running;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;

    typedef struct {
        int unsigned t;
        bit          rise;
        bit          fs;
    } ev_t;

    ev_t exp_q[$];

    bit          m_run;
    bit          m_mclk;
    bit          m_bclk;
    bit          m_lr;
    bit          m_mode;
    bit          m_prev_en;
    int          m_slot;
    int          m_bit;
    int          m_lock_n;
    int unsigned m_entry;
    int unsigned m_last_fall;

    i2s_clock_gen #(
        .mclk_half_div (MHD),
        .bclk_half_div (BHD),
        .slot_width    (SW),
        .n_slots       (NS)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .clk_lock    (clk_lock),
        .enable      (enable),
        .mode        (mode),
        .mclk        (mclk),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .bclk_rise   (bclk_rise),
        .bclk_fall   (bclk_fall),
        .frame_start (frame_start),
        .slot        (slot),
        .bit_idx     (bit_idx),
        .running     (running)
    );

    always #5 sys_clk = ~sys_clk;

    // One comparison: counts the vector and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Drive inputs just after a clock edge, then hold them for n cycles.
    task automatic applyStimulus(input bit l, input bit e, input bit md, input int n);
        @(posedge sys_clk);
        #1;
        clk_lock = l;
        enable   = e;
        mode     = md;
        repeat (n) @(posedge sys_clk);
    endtask

    // Wait until the model sits at a given slot/bit while running.
    task automatic waitPosition(input int s, input int b);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!(m_run && m_slot == s && m_bit == b) && n < 4 * FRAME * BP);
        if (n >= 4 * FRAME * BP) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wait_position: slot %0d bit %0d never reached", s, b);
        end
    endtask

    // Reference model. MCLK phase follows from the number of locked cycles;
    // once started, BCLK rises half a period and falls a whole period after
    // each period boundary counted from the start cycle. Fall k sits at frame
    // position k mod FRAME. LRCLK is the half-frame holding the next bit
    // (I2S) or flags the last bit of the frame (DSP). A frame boundary ends
    // the run when enable was low at both this and the previous edge.
    always @(posedge sys_clk or posedge reset) begin
        int age;
        int k;
        int pos;
        int nxt;
        if (reset) begin
            m_lock_n  = 0;
            m_run     = 1'b0;
            m_mclk    = 1'b0;
            m_bclk    = 1'b0;
            m_lr      = 1'b0;
            m_mode    = 1'b0;
            m_slot    = 0;
            m_bit     = 0;
            m_prev_en = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (!clk_lock) begin
                m_lock_n = 0;
                m_run    = 1'b0;
                m_bclk   = 1'b0;
                m_lr     = 1'b0;
                m_slot   = 0;
                m_bit    = 0;
            end else begin
                m_lock_n++;
                if (!m_run) begin
                    if (enable && (m_lock_n % (2 * MHD)) == MHD) begin
                        m_run   = 1'b1;
                        m_entry = cyc;
                        m_mode  = mode;
                        m_lr    = mode;
                        m_slot  = NS - 1;
                        m_bit   = SW - 1;
                        m_bclk  = 1'b0;
                    end
                end else begin
                    age = int'(cyc - m_entry);
                    if (age % BP == BP / 2) begin
                        m_bclk = 1'b1;
                        exp_q.push_back('{t: cyc, rise: 1'b1, fs: 1'b0});
                    end else if (age % BP == 0) begin
                        k           = age / BP - 1;
                        pos         = k % FRAME;
                        m_bclk      = 1'b0;
                        m_last_fall = cyc;
                        if (pos == 0 && !enable && !m_prev_en) begin
                            m_run  = 1'b0;
                            m_lr   = 1'b0;
                            m_slot = 0;
                            m_bit  = 0;
                            exp_q.push_back('{t: cyc, rise: 1'b0, fs: 1'b0});
                        end else begin
                            if (pos == 0) m_mode = mode;
                            m_slot = pos / SW;
                            m_bit  = pos % SW;
                            nxt    = (pos + 1) % FRAME;
                            m_lr   = m_mode ? (pos == FRAME - 1) : ((nxt / SW) >= NS / 2);
                            exp_q.push_back('{t: cyc, rise: 1'b0, fs: (pos == 0)});
                        end
                    end
                end
            end
            m_mclk    = ((m_lock_n / MHD) % 2) == 1;
            m_prev_en = enable;
        end
    end

    // Monitor: compares level outputs every cycle and pops one expected
    // strobe event whenever the DUT shows a strobe; an overdue expected
    // event with no DUT strobe is reported as missing.
    always @(negedge sys_clk) begin
        ev_t e;
        checkOutput("levels",
                    64'({mclk, bclk, lrclk, running, 8'(slot), 8'(bit_idx)}),
                    64'({m_mclk, m_bclk, m_lr, m_run, 8'(m_slot), 8'(m_bit)}));
        if (bclk_rise || bclk_fall || frame_start) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", 64'({bclk_rise, bclk_fall, frame_start}), 64'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("strobe",
                            64'({cyc, bclk_rise, bclk_fall, frame_start}),
                            64'({e.t, e.rise, !e.rise, e.fs}));
            end
        end else if (exp_q.size() != 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front();
            checkOutput("missing_strobe", 64'({cyc, 3'b000}), 64'({e.t, e.rise, !e.rise, e.fs}));
        end
    end

    initial begin
        int target;

        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("reset_state",
                    64'({mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, 8'(slot), 8'(bit_idx)}),
                    64'(0));
        reset = 1'b0;

        $display("[TB] default I2S run");
        applyStimulus(1'b1, 1'b1, 1'b0, 3200);

        $display("[TB] mid-frame switch to DSP");
        waitPosition(2, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 3000);

        $display("[TB] graceful stop from slot 0 bit 5");
        waitPosition(0, 5);
        applyStimulus(1'b1, 1'b0, mode, 2000);
        #1;
        checkOutput("stopped", 64'({bclk, lrclk, running, frame_start}), 64'(0));

        $display("[TB] enable drop coincident with frame_start");
        applyStimulus(1'b1, 1'b1, 1'b0, 1500);
        waitPosition(NS - 1, SW - 1);
        target = int'(m_last_fall) + BP - 1;
        do begin
            @(posedge sys_clk);
            #1;
        end while (int'(cyc) < target);
        enable = 1'b0;
        repeat (FRAME * BP + 2 * BP) @(posedge sys_clk);

        $display("[TB] enable reasserted while draining");
        applyStimulus(1'b1, 1'b1, 1'b1, 2000);
        applyStimulus(1'b1, 1'b0, 1'b1, 300);
        applyStimulus(1'b1, 1'b1, 1'b1, 2000);

        $display("[TB] lock loss mid-frame");
        waitPosition(3, 4);
        applyStimulus(1'b0, 1'b1, mode, 30);
        applyStimulus(1'b1, 1'b1, 1'b0, 2000);

        $display("[TB] asynchronous reset between edges");
        @(posedge sys_clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset",
                    64'({mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, 8'(slot), 8'(bit_idx)}),
                    64'(0));
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        repeat (3500) @(posedge sys_clk);

        $display("[TB] randomized enable/mode/lock sequence");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          int'($urandom_range(40, 2500)));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 2 * FRAME * BP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
